// File: rtl/ld3320_bus_arbiter.sv
// Round-robin arbiter/sequencer for the LD3320 bus engine. One command is in flight at a time.
// Each access is followed by an idle gap, and a WAIT watchdog keeps a stuck engine from hanging a client.
module ld3320_bus_arbiter #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       c0_req,
  input  logic       c0_wr,
  input  logic [7:0] c0_addr,
  input  logic [7:0] c0_wdata,
  output logic       c0_ack,
  output logic [7:0] c0_rdata,
  output logic       c0_err,
  input  logic       c1_req,
  input  logic       c1_wr,
  input  logic [7:0] c1_addr,
  input  logic [7:0] c1_wdata,
  output logic       c1_ack,
  output logic [7:0] c1_rdata,
  output logic       c1_err,
  output logic       eng_ena,
  output logic       eng_sel,
  output logic [7:0] eng_addr,
  output logic [7:0] eng_data,
  input  logic [7:0] eng_rdata,
  input  logic       eng_done,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  state_t     state;
  logic       last_grant;
  logic [7:0] tcnt;
  logic [7:0] gcnt;
  logic       pick;
  logic       finish;

  // Under contention the client that did not win last time goes next.
  assign pick   = (c0_req && c1_req) ? ~last_grant : c1_req;
  assign finish = eng_done || (tcnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      tcnt       <= 8'd0;
      gcnt       <= 8'd0;
      c0_ack     <= 1'b0;
      c0_err     <= 1'b0;
      c0_rdata   <= 8'd0;
      c1_ack     <= 1'b0;
      c1_err     <= 1'b0;
      c1_rdata   <= 8'd0;
      eng_ena    <= 1'b0;
      eng_sel    <= 1'b0;
      eng_addr   <= 8'd0;
      eng_data   <= 8'd0;
      busy       <= 1'b0;
    end else begin
      c0_ack  <= 1'b0;
      c1_ack  <= 1'b0;
      eng_ena <= 1'b0;
      case (state)
        S_IDLE: begin
          if (c0_req || c1_req) begin
            last_grant <= pick;
            grant_id   <= pick;
            eng_sel    <= pick ? c1_wr    : c0_wr;
            eng_addr   <= pick ? c1_addr  : c0_addr;
            eng_data   <= pick ? c1_wdata : c0_wdata;
            eng_ena    <= 1'b1;
            busy       <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tcnt  <= 8'd0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (finish) begin
            // A done arriving in the timeout cycle still counts as success.
            if (grant_id) begin
              c1_ack <= 1'b1;
              c1_err <= ~eng_done;
              if (eng_done && !eng_sel) c1_rdata <= eng_rdata;
            end else begin
              c0_ack <= 1'b1;
              c0_err <= ~eng_done;
              if (eng_done && !eng_sel) c0_rdata <= eng_rdata;
            end
            gcnt  <= 8'd0;
            state <= S_GAP;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_GAP: begin
          if (gcnt == 8'(GAP_CYCLES - 1)) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gcnt <= gcnt + 8'd1;
          end
        end
        default: begin
          state      <= S_IDLE;
          last_grant <= 1'b1;
          grant_id   <= 1'b0;
          tcnt       <= 8'd0;
          gcnt       <= 8'd0;
          c0_err     <= 1'b0;
          c0_rdata   <= 8'd0;
          c1_err     <= 1'b0;
          c1_rdata   <= 8'd0;
          eng_sel    <= 1'b0;
          eng_addr   <= 8'd0;
          eng_data   <= 8'd0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ld3320_bus_arbiter.sv
// Scoreboard bench for ld3320_bus_arbiter. An engine model predicts each access outcome from the grant rules,
// and a monitor checks every ack plus the held rdata/err against the reference state.
module tb_ld3320_bus_arbiter;
  localparam int GAP = 4;
  localparam int TO  = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      req = '0;
  logic [1:0]      wr = '0;
  logic [1:0][7:0] addr = '0;
  logic [1:0][7:0] wdata = '0;
  logic [1:0]      ack;
  logic [1:0]      err;
  logic [1:0][7:0] rdata;
  logic            eng_ena, eng_sel, busy, grant_id;
  logic [7:0]      eng_addr, eng_data;
  logic [7:0]      eng_rdata = 8'd0;
  logic            eng_done = 1'b0;

  ld3320_bus_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_req(req[0]), .c0_wr(wr[0]), .c0_addr(addr[0]), .c0_wdata(wdata[0]),
    .c0_ack(ack[0]), .c0_rdata(rdata[0]), .c0_err(err[0]),
    .c1_req(req[1]), .c1_wr(wr[1]), .c1_addr(addr[1]), .c1_wdata(wdata[1]),
    .c1_ack(ack[1]), .c1_rdata(rdata[1]), .c1_err(err[1]),
    .eng_ena(eng_ena), .eng_sel(eng_sel), .eng_addr(eng_addr), .eng_data(eng_data),
    .eng_rdata(eng_rdata), .eng_done(eng_done), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  logic [1:0] req_snap = '0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    req_snap <= req;
  end

  typedef struct {
    int         client;
    logic       err;
    logic [7:0] rdata;
    int         cyc;
  } exp_t;

  exp_t       sbq[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] rdata_m[2] = '{8'd0, 8'd0};
  logic       err_m[2] = '{1'b0, 1'b0};
  logic       last_m = 1'b1;
  int         mode = 0;           // 0 std, 1 random, 2 never+late done, 3 done at timeout, 4 never
  int         fixed_rv = -1;
  int         last_ack = -1000;
  int         prev_ena = -1;
  bit         exact_spacing = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Engine model: predicts winner and outcome when it sees a start pulse.
  task automatic serve();
    int e, k, fin, w;
    bit ok, late;
    logic [7:0] rv;
    logic [16:0] cmd;
    exp_t x;
    e  = cyc;
    rv = (fixed_rv >= 0) ? 8'(fixed_rv) : 8'($urandom);
    chk("grant_had_request", {63'd0, req_snap != 2'b00}, 64'd1);
    w = (req_snap == 2'b11) ? (last_m ? 0 : 1) : (req_snap[1] ? 1 : 0);
    last_m = (w == 1);
    chk("grant_id", {63'd0, grant_id}, w);
    chk("busy_in_issue", {63'd0, busy}, 64'd1);
    chk("eng_sel", {63'd0, eng_sel}, {63'd0, wr[w]});
    chk("eng_addr", {56'd0, eng_addr}, {56'd0, addr[w]});
    if (wr[w]) chk("eng_data", {56'd0, eng_data}, {56'd0, wdata[w]});
    chk("gap_respected", {63'd0, e >= last_ack + GAP + 1}, 64'd1);
    if (exact_spacing && prev_ena >= 0) chk("ena_spacing", e - prev_ena, 9 + GAP);
    prev_ena = e;
    late = 1'b0;
    case (mode)
      0: k = 7;
      1: k = $urandom_range(40, 1);
      2: begin k = 1000; late = 1'b1; end
      3: k = TO;
      default: k = 1000;
    endcase
    ok  = (k <= TO);
    fin = ok ? e + k : (late ? e + TO + 2 : e + TO + 1);
    x.client = w;
    x.err    = !ok;
    x.rdata  = (ok && !wr[w]) ? rv : rdata_m[w];
    x.cyc    = ok ? e + k + 1 : e + TO + 1;
    sbq.push_back(x);
    cmd = {eng_sel, eng_addr, eng_data};
    while (cyc < fin) begin
      @(negedge clk);
      if (!rst_n) break;
      eng_done  = (cyc == e + k) || (late && cyc == e + TO + 2);
      eng_rdata = eng_done ? rv : 8'($urandom);
      chk("ena_single_pulse", {63'd0, eng_ena}, 64'd0);
      if (cyc <= (ok ? e + k : e + TO))
        chk("eng_cmd_stable", {47'd0, eng_sel, eng_addr, eng_data}, {47'd0, cmd});
    end
    @(negedge clk);
    eng_done = 1'b0;
  endtask

  initial begin : engine
    forever begin
      @(negedge clk);
      if (rst_n && eng_ena) serve();
    end
  end

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      for (int c = 0; c < 2; c++) begin
        if (ack[c]) begin
          if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ack: client %0d acked with nothing outstanding at cycle %0d", c, cyc);
          end else begin
            x = sbq.pop_front();
            chk("ack_client", c, x.client);
            chk("ack_err", {63'd0, err[c]}, {63'd0, x.err});
            chk("ack_cycle", cyc, x.cyc);
            rdata_m[c] = x.rdata;
            err_m[c]   = x.err;
            last_ack   = cyc;
          end
        end
        chk("rdata_model", {56'd0, rdata[c]}, {56'd0, rdata_m[c]});
        chk("err_model", {63'd0, err[c]}, {63'd0, err_m[c]});
      end
    end
  end

  task automatic client_req(input int c, input logic w, input logic [7:0] a, input logic [7:0] d,
                            output int lat);
    int t0, t;
    t0 = cyc;
    t  = 0;
    wr[c] = w; addr[c] = a; wdata[c] = d; req[c] = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!ack[c] && t < 300 && rst_n);
    if (!ack[c]) begin
      tests++;
      fails++;
      $display("FAIL ack_wait: client %0d got no ack within %0d cycles", c, t);
    end
    req[c] = 1'b0;
    lat = cyc - t0;
  endtask

  task automatic client_loop(input int c, input int n, input int maxgap);
    int lat;
    for (int i = 0; i < n; i++) begin
      repeat (1 + $urandom_range(maxgap, 0)) @(negedge clk);
      client_req(c, 1'($urandom), {c[0], 7'($urandom)}, 8'($urandom), lat);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {24'd0, ack, err, rdata, eng_ena, eng_sel, eng_addr, eng_data, busy, grant_id}, 64'd0);
  endtask

  initial begin : main
    int lat0, lat1, t;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("post_reset_idle");

    // Client 0 write
    mode = 0;
    client_req(0, 1'b1, 8'h37, 8'h04, lat0);
    chk("c0_write_latency", lat0, 9);
    repeat (GAP + 2) @(negedge clk);

    // Client 1 read returning 0x5A
    fixed_rv = 8'h5A;
    client_req(1, 1'b0, 8'hC5, 8'h00, lat1);
    chk("c1_read_latency", lat1, 9);
    chk("c1_read_data", {56'd0, rdata[1]}, 64'h5A);
    chk("c1_grant_id", {63'd0, grant_id}, 64'd1);
    fixed_rv = -1;
    repeat (GAP + 2) @(negedge clk);

    // Both clients continuously requesting
    exact_spacing = 1'b1;
    prev_ena = -1;
    fork
      client_loop(0, 4, 0);
      client_loop(1, 4, 0);
    join
    exact_spacing = 1'b0;
    repeat (GAP + 2) @(negedge clk);

    // Engine never finishes; a late done lands in the gap
    mode = 2;
    client_req(0, 1'b0, 8'h12, 8'h00, lat0);
    chk("timeout_latency", lat0, TO + 2);
    chk("timeout_err", {63'd0, err[0]}, 64'd1);
    repeat (GAP + 4) @(negedge clk);
    mode = 0;
    client_req(0, 1'b1, 8'h21, 8'h99, lat0);
    chk("after_timeout_latency", lat0, 9);
    chk("after_timeout_err_clear", {63'd0, err[0]}, 64'd0);
    repeat (GAP + 2) @(negedge clk);

    // Done coincident with the timeout cycle
    mode = 3;
    fixed_rv = 8'hA5;
    client_req(1, 1'b0, 8'h2B, 8'h00, lat1);
    chk("coincident_err", {63'd0, err[1]}, 64'd0);
    chk("coincident_rdata", {56'd0, rdata[1]}, 64'hA5);
    fixed_rv = -1;
    repeat (GAP + 2) @(negedge clk);

    // Randomized traffic with random engine latency
    mode = 1;
    fork
      client_loop(0, 12, 15);
      client_loop(1, 12, 15);
    join
    repeat (TO + GAP + 4) @(negedge clk);

    // Reset in the middle of WAIT
    mode = 4;
    wr[0] = 1'b0; addr[0] = 8'h44; req[0] = 1'b1;
    t = 0;
    while (!eng_ena && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("reset_test_issue", {63'd0, eng_ena}, 64'd1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset_outputs");
    req = '0;
    sbq.delete();
    rdata_m = '{8'd0, 8'd0};
    err_m = '{1'b0, 1'b0};
    last_m = 1'b1;
    last_ack = -1000;
    prev_ena = -1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_hold_outputs");
    rst_n = 1'b1;
    mode = 0;
    @(negedge clk);
    fork
      client_req(0, 1'b1, 8'h0A, 8'h3C, lat0);
      client_req(1, 1'b1, 8'h8A, 8'hC3, lat1);
    join
    chk("post_reset_c0_first", lat0, 9);
    repeat (GAP + 4) @(negedge clk);

    chk("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
